// File: rtl/cgs_multilane.sv
// Multi-lane code-group synchronisation: one INIT/DATA/CHECK tracker per lane,
// a combined registered SYNC~ and saturating per-lane loss-of-sync counters.
module cgs_multilane #(
  parameter int NUM_LANES       = 4,
  parameter int PARALLEL_OCTETS = 4,
  parameter int CGS_HOLD_WINDOW = 4,
  parameter int CGS_TOLERANCE   = 4,
  parameter int CNT_W           = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_LANES-1:0]                 lane_enable_i,
  input  logic [NUM_LANES*PARALLEL_OCTETS-1:0] char_cgs_i,
  input  logic [NUM_LANES*PARALLEL_OCTETS-1:0] char_error_i,
  input  logic                                 resync_i,
  input  logic                                 cnt_clr_i,
  output logic [NUM_LANES-1:0]                 lane_synced_o,
  output logic                                 sync_n_o,
  output logic [NUM_LANES*CNT_W-1:0]           loss_cnt_o
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } lane_state_e;

  localparam logic [3:0] HOLD_W = 4'(CGS_HOLD_WINDOW);
  localparam logic [3:0] TOL_W  = 4'(CGS_TOLERANCE);

  lane_state_e      state_q   [NUM_LANES];
  lane_state_e      state_d   [NUM_LANES];
  logic [3:0]       run_q     [NUM_LANES];
  logic [3:0]       run_d     [NUM_LANES];
  logic [3:0]       err_cnt_q [NUM_LANES];
  logic [3:0]       err_cnt_d [NUM_LANES];
  logic [CNT_W-1:0] loss_q    [NUM_LANES];
  logic [CNT_W-1:0] loss_d    [NUM_LANES];
  logic             sync_n_q;
  logic             sync_n_d;
  logic [NUM_LANES-1:0] loss_ev;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] max_v;
    max_v = '1;
    return (v == max_v) ? v : v + 1'b1;
  endfunction

  // Per-lane beat classification and state transitions
  always_comb begin
    logic [PARALLEL_OCTETS-1:0] cgs_l;
    logic [PARALLEL_OCTETS-1:0] err_l;
    logic                       good_k;
    logic                       any_err;
    logic                       full_err;
    logic [3:0]                 run_inc;
    logic [3:0]                 err_inc;
    for (int l = 0; l < NUM_LANES; l++) begin
      cgs_l    = char_cgs_i[l*PARALLEL_OCTETS +: PARALLEL_OCTETS];
      err_l    = char_error_i[l*PARALLEL_OCTETS +: PARALLEL_OCTETS];
      good_k   = (&cgs_l) & ~(|err_l);
      any_err  = |err_l;
      full_err = &err_l;
      run_inc  = run_q[l] + 4'd1;
      err_inc  = err_cnt_q[l] + 4'd1;

      state_d[l]   = state_q[l];
      run_d[l]     = run_q[l];
      err_cnt_d[l] = err_cnt_q[l];
      loss_ev[l]   = 1'b0;

      if (resync_i || !lane_enable_i[l]) begin
        state_d[l]   = ST_INIT;
        run_d[l]     = 4'd0;
        err_cnt_d[l] = 4'd0;
      end else begin
        case (state_q[l])
          ST_INIT: begin
            if (good_k) begin
              run_d[l] = run_inc;
              if (run_inc == HOLD_W) begin
                state_d[l]   = ST_DATA;
                run_d[l]     = 4'd0;
                err_cnt_d[l] = 4'd0;
              end
            end else begin
              run_d[l] = 4'd0;
            end
          end
          ST_DATA: begin
            if (any_err) begin
              state_d[l]   = ST_CHECK;
              err_cnt_d[l] = 4'd1;
              run_d[l]     = 4'd0;
            end
          end
          ST_CHECK: begin
            if (full_err) begin
              state_d[l]   = ST_INIT;
              run_d[l]     = 4'd0;
              err_cnt_d[l] = 4'd0;
              loss_ev[l]   = 1'b1;
            end else if (any_err) begin
              run_d[l]     = 4'd0;
              err_cnt_d[l] = err_inc;
              // >= so a tolerance of 1 still exits even though entry preloads 1
              if (err_inc >= TOL_W) begin
                state_d[l]   = ST_INIT;
                err_cnt_d[l] = 4'd0;
                loss_ev[l]   = 1'b1;
              end
            end else begin
              run_d[l] = run_inc;
              if (run_inc == HOLD_W) begin
                state_d[l]   = ST_DATA;
                run_d[l]     = 4'd0;
                err_cnt_d[l] = 4'd0;
              end
            end
          end
          default: begin
            state_d[l]   = ST_INIT;
            run_d[l]     = 4'd0;
            err_cnt_d[l] = 4'd0;
          end
        endcase
      end

      if (cnt_clr_i) begin
        loss_d[l] = '0;
      end else if (loss_ev[l]) begin
        loss_d[l] = sat_inc(loss_q[l]);
      end else begin
        loss_d[l] = loss_q[l];
      end
    end
  end

  // SYNC~ aggregation across enabled lanes from registered lane status
  always_comb begin
    logic all_ok;
    all_ok = 1'b1;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (lane_enable_i[l] && !lane_synced_o[l]) begin
        all_ok = 1'b0;
      end
    end
    sync_n_d = (|lane_enable_i) & all_ok & ~resync_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        state_q[l]   <= ST_INIT;
        run_q[l]     <= 4'd0;
        err_cnt_q[l] <= 4'd0;
        loss_q[l]    <= '0;
      end
      sync_n_q <= 1'b0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        state_q[l]   <= state_d[l];
        run_q[l]     <= run_d[l];
        err_cnt_q[l] <= err_cnt_d[l];
        loss_q[l]    <= loss_d[l];
      end
      sync_n_q <= sync_n_d;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_out
    assign lane_synced_o[g]              = (state_q[g] != ST_INIT);
    assign loss_cnt_o[g*CNT_W +: CNT_W]  = loss_q[g];
  end

  assign sync_n_o = sync_n_q;

endmodule

// File: tb/tb_cgs_multilane.sv
// Bench for cgs_multilane: directed scenarios plus randomized beats, all checked
// each cycle against a behavioural per-lane model.
module tb_cgs_multilane;
  localparam int NL  = 4;
  localparam int P   = 4;
  localparam int HW  = 4;
  localparam int TOL = 4;
  localparam int CW  = 3;
  localparam int LOSS_MAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst, resync, clr;
  logic [NL-1:0]     en;
  logic [NL*P-1:0]   cgs, err;
  logic [NL-1:0]     synced;
  logic              sync_n;
  logic [NL*CW-1:0]  loss;

  int n_tests = 0;
  int n_fail  = 0;

  // model: state 0 = INIT, 1 = DATA, 2 = CHECK
  int m_st   [NL];
  int m_run  [NL];
  int m_err  [NL];
  int m_loss [NL];
  bit m_sync_n;

  always #5 clk = ~clk;

  cgs_multilane #(
    .NUM_LANES(NL), .PARALLEL_OCTETS(P), .CGS_HOLD_WINDOW(HW),
    .CGS_TOLERANCE(TOL), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .lane_enable_i(en), .char_cgs_i(cgs),
    .char_error_i(err), .resync_i(resync), .cnt_clr_i(clr),
    .lane_synced_o(synced), .sync_n_o(sync_n), .loss_cnt_o(loss)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode: 0 good_k, 1 single-octet error, 2 all-octet error, 3 garbage, 4 good non-K
  task automatic set_lane(input int l, input int mode);
    logic [P-1:0] c, e;
    case (mode)
      0: begin c = '1; e = '0; end
      1: begin c = '1; e = '0; e[$urandom_range(P-1, 0)] = 1'b1; end
      2: begin c = P'($urandom); e = '1; end
      3: begin c = P'($urandom); e = P'($urandom); end
      default: begin c = P'($urandom); c[0] = 1'b0; e = '0; end
    endcase
    cgs[l*P +: P] = c;
    err[l*P +: P] = e;
  endtask

  task automatic all_lanes(input int mode);
    for (int l = 0; l < NL; l++) set_lane(l, mode);
  endtask

  task automatic model_step();
    bit any_en, all_ok, gk, anyerr, full;
    int ne, nk, prev;
    if (rst) begin
      for (int l = 0; l < NL; l++) begin
        m_st[l] = 0; m_run[l] = 0; m_err[l] = 0; m_loss[l] = 0;
      end
      m_sync_n = 1'b0;
      return;
    end
    any_en = 0;
    all_ok = 1;
    for (int l = 0; l < NL; l++) begin
      if (en[l]) begin
        any_en = 1;
        if (m_st[l] == 0) all_ok = 0;
      end
    end
    for (int l = 0; l < NL; l++) begin
      nk     = $countones(cgs[l*P +: P]);
      ne     = $countones(err[l*P +: P]);
      gk     = (nk == P) && (ne == 0);
      anyerr = (ne > 0);
      full   = (ne == P);
      prev   = m_st[l];
      if (resync || !en[l]) begin
        m_st[l] = 0; m_run[l] = 0; m_err[l] = 0;
      end else if (prev == 0) begin
        m_run[l] = gk ? m_run[l] + 1 : 0;
        if (m_run[l] == HW) begin
          m_st[l] = 1; m_run[l] = 0; m_err[l] = 0;
        end
      end else if (prev == 1) begin
        if (anyerr) begin
          m_st[l] = 2; m_err[l] = 1; m_run[l] = 0;
        end
      end else begin
        if (full) begin
          m_st[l] = 0; m_run[l] = 0; m_err[l] = 0;
        end else if (anyerr) begin
          m_err[l] = m_err[l] + 1;
          m_run[l] = 0;
          if (m_err[l] >= TOL) begin
            m_st[l] = 0; m_err[l] = 0;
          end
        end else begin
          m_run[l] = m_run[l] + 1;
          if (m_run[l] == HW) begin
            m_st[l] = 1; m_run[l] = 0; m_err[l] = 0;
          end
        end
      end
      if (clr) m_loss[l] = 0;
      else if (prev == 2 && m_st[l] == 0 && en[l] && !resync && m_loss[l] < LOSS_MAX)
        m_loss[l] = m_loss[l] + 1;
    end
    m_sync_n = any_en && all_ok && !resync;
  endtask

  task automatic cycle();
    logic [NL-1:0]    exp_s;
    logic [NL*CW-1:0] exp_l;
    @(posedge clk);
    model_step();
    #1;
    for (int l = 0; l < NL; l++) begin
      exp_s[l]           = (m_st[l] != 0);
      exp_l[l*CW +: CW]  = CW'(m_loss[l]);
    end
    check("synced", synced, exp_s);
    check("sync_n", sync_n, m_sync_n);
    check("loss_cnt", loss, exp_l);
  endtask

  // acquire every enabled lane, then lose lane l via two all-error beats
  task automatic lose_lane(input int l);
    all_lanes(0);
    repeat (HW) cycle();
    set_lane(l, 2);
    repeat (2) cycle();
    all_lanes(0);
  endtask

  initial begin
    rst = 1'b1; resync = 1'b0; clr = 1'b0; en = '1; cgs = '0; err = '0;
    repeat (2) cycle();
    check("rst_synced", synced, 0);
    check("rst_sync_n", sync_n, 0);
    check("rst_loss", loss, 0);
    rst = 1'b0;

    // four good_k beats acquire, SYNC~ follows a cycle later
    all_lanes(0);
    repeat (HW) cycle();
    check("acq_synced", synced, 4'hF);
    check("acq_sync_n_lag", sync_n, 0);
    cycle();
    check("acq_sync_n", sync_n, 1);

    // lane 2: three single-octet errors then four good beats
    repeat (3) begin set_lane(2, 1); cycle(); check("chk_lane2_held", synced[2], 1); end
    repeat (HW) begin set_lane(2, 4); cycle(); end
    check("chk_lane2_synced", synced[2], 1);
    check("chk_lane2_loss", loss[2*CW +: CW], 0);
    all_lanes(0);

    // lane 1: tolerance run of error beats drops sync
    repeat (TOL) begin set_lane(1, 1); cycle(); end
    check("tol_lane1_synced", synced[1], 0);
    check("tol_lane1_loss", loss[1*CW +: CW], 1);
    set_lane(1, 4);
    cycle();
    check("tol_sync_n", sync_n, 0);

    // lane 0: repeated losses saturate the counter
    repeat (LOSS_MAX + 2) lose_lane(0);
    check("sat_lane0_loss", loss[0 +: CW], LOSS_MAX);

    // lane 3: clear wins over a coincident loss
    repeat (LOSS_MAX) lose_lane(3);
    check("pre_clr_lane3_loss", loss[3*CW +: CW], LOSS_MAX);
    repeat (HW) cycle();
    set_lane(3, 2);
    cycle();
    set_lane(3, 2);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("clr_lane3_loss", loss[3*CW +: CW], 0);
    all_lanes(0);

    // partial enable with garbage on disabled lanes, then resync
    en = 4'b0101;
    set_lane(0, 0); set_lane(2, 0); set_lane(1, 3); set_lane(3, 3);
    repeat (HW + 1) cycle();
    check("mask_sync_n", sync_n, 1);
    resync = 1'b1;
    cycle();
    resync = 1'b0;
    check("resync_synced", synced, 0);
    check("resync_sync_n", sync_n, 0);
    cycle();

    en = '0;
    all_lanes(0);
    repeat (HW + 2) cycle();
    check("none_en_sync_n", sync_n, 0);
    en = '1;

    // randomized beats
    for (int i = 0; i < 3000; i++) begin
      int r;
      for (int l = 0; l < NL; l++) begin
        r = $urandom_range(99, 0);
        if      (r < 60) set_lane(l, 0);
        else if (r < 75) set_lane(l, 1);
        else if (r < 80) set_lane(l, 2);
        else if (r < 90) set_lane(l, 3);
        else             set_lane(l, 4);
      end
      rst    = ($urandom_range(199, 0) == 0);
      resync = ($urandom_range(99, 0) == 0);
      clr    = ($urandom_range(59, 0) == 0);
      if ($urandom_range(49, 0) == 0) en = NL'($urandom);
      else if ($urandom_range(49, 0) == 0) en = '1;
      cycle();
    end
    rst = 1'b0; resync = 1'b0; clr = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cgs_multilane.md
CGS_MULTILANE -- requirements
Module: cgs_multilane

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of independent receive lanes (1..16).
REQ-002 SHALL have parameter PARALLEL_OCTETS, default 4, octets per lane per beat.
REQ-003 SHALL have parameter CGS_HOLD_WINDOW, default 4, consecutive qualifying beats needed to acquire or re-acquire (1..15).
REQ-004 SHALL have parameter CGS_TOLERANCE, default 4, consecutive error beats in CHECK that cause loss of sync (1..15).
REQ-005 SHALL have parameter CNT_W, default 8, width of each per-lane loss counter.
REQ-006 SHALL have port clk_i  input  1  single clock; all logic on the rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port lane_enable_i  input  NUM_LANES  per-lane enable mask.
REQ-009 SHALL have port char_cgs_i  input  NUM_LANES*PARALLEL_OCTETS  /K/ flag per octet; lane l uses bits [l*PARALLEL_OCTETS +: PARALLEL_OCTETS].
REQ-010 SHALL have port char_error_i  input  NUM_LANES*PARALLEL_OCTETS  disparity/not-in-table flag per octet, same packing.
REQ-011 SHALL have port resync_i  input  1  one-cycle request forcing all lanes back to INIT.
REQ-012 SHALL have port cnt_clr_i  input  1  clears all loss counters.
REQ-013 SHALL have port lane_synced_o  output  NUM_LANES  lane state is not INIT.
REQ-014 SHALL have port sync_n_o  output  1  active-low SYNC~ to transmitter, registered.
REQ-015 SHALL have port loss_cnt_o  output  NUM_LANES*CNT_W  per-lane saturating loss-of-sync count, same lane packing.

Function
REQ-016 Per lane, beat classes: good_k = all octets cgs and no octet error; err = any octet error; full_err = all octets error; good = no octet error.
REQ-017 Each lane SHALL run an independent FSM with states INIT, DATA, CHECK, plus a 4-bit run counter and 4-bit error counter.
REQ-018 INIT: good_k beat increments run counter, any other beat clears it; beat making it equal CGS_HOLD_WINDOW -> DATA, counters cleared.
REQ-019 DATA: err beat -> CHECK with error counter = 1, run counter = 0; otherwise stay.
REQ-020 CHECK: full_err beat -> INIT; err beat increments error counter, clears run counter, and -> INIT when new value equals CGS_TOLERANCE.
REQ-021 CHECK: good beat increments run counter (error counter held); beat making it equal CGS_HOLD_WINDOW -> DATA, both counters cleared.
REQ-022 CGS_TOLERANCE = 1 SHALL make any err beat in CHECK return to INIT; CGS_HOLD_WINDOW = 1 SHALL acquire on a single good_k beat.
REQ-023 A lane with lane_enable_i low SHALL be held in INIT with counters cleared; loss counter unaffected.
REQ-024 resync_i high SHALL force every lane to INIT with counters cleared next cycle, overriding all transitions; resync-caused exits SHALL NOT count as losses.
REQ-025 lane_synced_o[l] SHALL be decoded from registered state (high in DATA or CHECK): high in cycle t+1 after the acquiring beat at t.
REQ-026 sync_n_o SHALL register 1 when at least one lane is enabled, every enabled lane has lane_synced_o high, and resync_i is low; else 0 (latency two cycles from acquiring beat).
REQ-027 loss_cnt_o[l] SHALL increment by 1 on each CHECK->INIT transition of lane l, saturating at 2^CNT_W-1.
REQ-028 cnt_clr_i SHALL zero all loss counters next cycle, taking priority over a simultaneous increment.
REQ-029 Disabled lanes SHALL be ignored by sync_n_o; all lanes disabled SHALL give sync_n_o = 0.

Reset
REQ-030 With rst_i high at a clock edge, all lanes SHALL enter INIT, all counters 0, lane_synced_o = 0, sync_n_o = 0, loss_cnt_o = 0.
REQ-031 Reset asserted mid-acquisition or mid-CHECK SHALL discard partial counts; no loss counted.

Verification
REQ-032 Defaults, all enabled, 4 good_k beats on every lane from cycle 0 -> lane_synced_o = 4'hF at cycle 4, sync_n_o = 1 at cycle 5.
REQ-033 Lane 2 synced, 3 consecutive single-octet err beats then 4 good beats -> CHECK, back to DATA, lane_synced_o[2] stays 1, loss_cnt 0.
REQ-034 Lane 1 synced, 4 consecutive err beats -> INIT after 4th, lane_synced_o[1] = 0 next cycle, sync_n_o = 0 cycle after, loss_cnt_o[1] = 1.
REQ-035 Lane 0 in DATA, one full_err beat then one full_err beat -> CHECK then INIT; CNT_W = 2, repeat loss 5 times -> loss_cnt_o[0] = 3 (saturated).
REQ-036 lane_enable_i = 4'b0101, lanes 0 and 2 acquire while lanes 1/3 receive garbage -> sync_n_o = 1; resync_i pulse -> all lanes INIT, sync_n_o = 0, loss counts unchanged.
REQ-037 cnt_clr_i and a loss event in same cycle with loss_cnt_o[3] = 7 -> loss_cnt_o[3] = 0.
